pc_sequencer: RTL and testbench

- Multi-cycle instruction sequencer that owns the program counter and the branch unit's 3-bit BRANCH code.
- Fetches from instruction memory over a req/ack handshake, holds the instruction through decode, drives the branch code during EXEC, and captures the branch unit's NPC.
- Commits the new PC on retire.
- Sits between instruction memory, the decoder and the branch control datapath; also keeps retire and taken-branch counters.

---
 rtl/pc_sequencer_pkg.sv | 35 +++
 rtl/pc_sequencer_if.sv | 16 +
 rtl/pc_sequencer_sat_counter.sv | 30 +++
 rtl/pc_sequencer.sv | 118 +++++++++++
 tb/tb_pc_sequencer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// cpu_ctrl_pkg: shared constants for the instruction sequencer.
//   - branch codes understood by the branch control datapath
//   - sequencer state encoding
//   - PC increment and branch-code classification helpers
package cpu_ctrl_pkg;

  // Branch codes (3'b110 / 3'b111 are illegal)
  localparam logic [2:0] NB  = 3'b000;
  localparam logic [2:0] BR  = 3'b001;
  localparam logic [2:0] BMI = 3'b010;
  localparam logic [2:0] BPL = 3'b011;
  localparam logic [2:0] BZ  = 3'b100;
  localparam logic [2:0] JR  = 3'b101;

  // Sequencer states
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [2:0] WB     = 3'd5;
  localparam logic [2:0] HALT   = 3'd6;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Codes that can redirect the PC (everything legal except NB)
  function automatic logic is_redirect(input logic [2:0] code);
    return (code != NB) && !(code[2] && code[1]);
  endfunction

  function automatic logic is_illegal(input logic [2:0] code);
    return code[2] && code[1];
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake.
//   imem_req   : sequencer -> memory, held until ack
//   imem_addr  : sequencer -> memory, fetch address (= pc)
//   imem_ack   : memory -> sequencer, one-cycle pulse
//   imem_rdata : memory -> sequencer, valid with imem_ack
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ack, input  imem_rdata);
  modport slave  (input  imem_req, input  imem_addr,
                  output imem_ack, output imem_rdata);
endinterface

// File: rtl/pc_sequencer_sat_counter.sv
// sat_counter: W-bit event counter with synchronous active-high reset.
//   clk, rst : clock / reset (clears to 0)
//   inc      : count one event this cycle
//   cnt      : current count; SAT=1 holds at all-ones, SAT=0 wraps
module sat_counter #(
  parameter int W   = 16,
  parameter bit SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(SAT && (&cnt_q)))
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/decode/exec/mem/wb sequencer owning the PC.
//   clk, rst          : clock, synchronous active-high reset
//   run               : level, allows a new fetch
//   imem              : fetch handshake (master side)
//   instr/instr_valid : latched instruction, valid pulse in DECODE
//   dec_branch/mem/halt, mem_done : decoder and memory-phase inputs
//   pc, pc_plus       : current PC and PC+4 for the branch unit
//   branch_sel/npc_in : branch unit control out, next PC back in
//   halted, fault     : HALT state, sticky fault
//   retire_cnt (wraps), taken_cnt (saturates)
module pc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  pc_sequencer_if.master    imem,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic [2:0]        dec_branch,
  input  logic              dec_mem,
  input  logic              dec_halt,
  input  logic              mem_done,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus,
  output logic [2:0]        branch_sel,
  input  logic [31:0]       npc_in,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] npc_q, npc_d;
  logic        fault_q, fault_d;
  logic        taken_inc, retire_inc;

  assign pc_plus = pc_q + PC_STEP;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    npc_d   = npc_q;
    fault_d = fault_q;
    case (state_q)
      IDLE:   if (run) state_d = FETCH;
      FETCH:  if (imem.imem_ack) begin
                instr_d = imem.imem_rdata;
                state_d = DECODE;
              end
      DECODE: if (dec_halt)                  state_d = HALT;
              else if (is_illegal(dec_branch)) begin
                fault_d = 1'b1;
                state_d = HALT;
              end else                       state_d = EXEC;
      EXEC:   begin
                npc_d   = npc_in;
                state_d = dec_mem ? MEM : WB;
              end
      MEM:    if (mem_done) state_d = WB;
      WB:     if (npc_q[1:0] != 2'b00) begin
                // misaligned target: keep the old PC so it points at the culprit
                fault_d = 1'b1;
                state_d = HALT;
              end else begin
                pc_d    = npc_q;
                state_d = run ? FETCH : IDLE;
              end
      HALT:   state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      npc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      fault_q <= fault_d;
    end
  end

  // A redirect counts as taken only when the branch unit moved off the fall-through
  assign taken_inc  = (state_q == EXEC) && is_redirect(dec_branch) && (npc_in != pc_plus);
  assign retire_inc = (state_q == WB) && (npc_q[1:0] == 2'b00);

  sat_counter #(.W(CNT_W), .SAT(1'b1)) u_taken_cnt (
    .clk(clk), .rst(rst), .inc(taken_inc), .cnt(taken_cnt)
  );

  sat_counter #(.W(CNT_W), .SAT(1'b0)) u_retire_cnt (
    .clk(clk), .rst(rst), .inc(retire_inc), .cnt(retire_cnt)
  );

  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = (state_q == DECODE);
  assign pc             = pc_q;
  assign branch_sel     = (state_q == EXEC) ? dec_branch : NB;
  assign halted         = (state_q == HALT);
  assign fault          = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; counters narrowed to 4 bits so
// saturation and wrap are reached in a few dozen instructions.
module tb_pc_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, run;
  logic [31:0]   instr, pc, pc_plus, npc_in;
  logic          instr_valid, dec_mem, dec_halt, mem_done, halted, fault;
  logic [2:0]    dec_branch, branch_sel;
  logic [CW-1:0] retire_cnt, taken_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;

  pc_sequencer_if ifc ();

  pc_sequencer #(.RESET_PC(32'h0), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run(run), .imem(ifc),
    .instr(instr), .instr_valid(instr_valid),
    .dec_branch(dec_branch), .dec_mem(dec_mem), .dec_halt(dec_halt),
    .mem_done(mem_done), .pc(pc), .pc_plus(pc_plus),
    .branch_sel(branch_sel), .npc_in(npc_in), .halted(halted),
    .fault(fault), .retire_cnt(retire_cnt), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for imem_req, then ack one cycle later; ends in DECODE.
  task automatic fetch_ack(input logic [31:0] data);
    int n = 0;
    while (!ifc.imem_req && n < 10) begin step(); n++; end
    chk("req_seen", {31'd0, ifc.imem_req}, 32'd1);
    chk("imem_addr", ifc.imem_addr, exp_pc);
    step();
    chk("req_held", {31'd0, ifc.imem_req}, 32'd1);
    ifc.imem_ack   = 1'b1;
    ifc.imem_rdata = data;
    step();
    ifc.imem_ack   = 1'b0;
  endtask

  task automatic exec_simple(input logic [2:0] br, input logic [31:0] npc);
    dec_branch = br; dec_mem = 1'b0; dec_halt = 1'b0; npc_in = npc;
    fetch_ack($urandom);
    step(); step(); step();
    exp_pc = npc;
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; dec_branch = NB; dec_mem = 1'b0; dec_halt = 1'b0;
    mem_done = 1'b0; npc_in = '0; ifc.imem_ack = 1'b0; ifc.imem_rdata = '0;
    exp_pc = 32'h0;
    step(); step();

    // Reset state
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_req", {31'd0, ifc.imem_req}, 32'd0);
    chk("rst_bsel", {29'd0, branch_sel}, {29'd0, NB});
    chk("rst_flags", {28'd0, halted, fault, instr_valid, 1'b0}, 32'd0);
    chk("rst_retire", {28'd0, retire_cnt}, 32'd0);
    chk("rst_taken", {28'd0, taken_cnt}, 32'd0);

    // Straight-line: first instruction with latency check
    rst = 1'b0; run = 1'b1;
    dec_branch = NB; npc_in = 32'h4;
    fetch_ack(32'hA5A5_0001);
    chk("dec_valid", {31'd0, instr_valid}, 32'd1);
    chk("dec_instr", instr, 32'hA5A5_0001);
    chk("lat_dec_req", {31'd0, ifc.imem_req}, 32'd0);
    step();
    chk("lat_exec_req", {31'd0, ifc.imem_req}, 32'd0);
    chk("exec_valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("lat_wb_req", {31'd0, ifc.imem_req}, 32'd0);
    chk("wb_instr_stable", instr, 32'hA5A5_0001);
    step();
    chk("lat_req_rise", {31'd0, ifc.imem_req}, 32'd1);
    chk("pc_4", pc, 32'h4);
    exp_pc = 32'h4;
    exec_simple(NB, 32'h8);
    chk("pc_8", pc, 32'h8);
    chk("retire_2", {28'd0, retire_cnt}, 32'd2);
    exec_simple(NB, 32'hC);
    exec_simple(NB, 32'h10);
    chk("pc_10", pc, 32'h10);

    // Taken BZ 0x10 -> 0x40
    dec_branch = BZ; npc_in = 32'h40;
    fetch_ack(32'h0000_BEEF);
    chk("bz_bsel_dec", {29'd0, branch_sel}, {29'd0, NB});
    step();
    chk("bz_bsel_exec", {29'd0, branch_sel}, {29'd0, BZ});
    step();
    chk("bz_bsel_wb", {29'd0, branch_sel}, {29'd0, NB});
    step();
    exp_pc = 32'h40;
    chk("bz_pc", pc, 32'h40);
    chk("bz_taken", {28'd0, taken_cnt}, 32'd1);

    // BMI not taken (npc = pc+4)
    exec_simple(BMI, 32'h44);
    chk("bmi_pc", pc, 32'h44);
    chk("bmi_taken", {28'd0, taken_cnt}, 32'd1);

    // JR taken
    exec_simple(JR, 32'h100);
    chk("jr_pc", pc, 32'h100);
    chk("jr_taken", {28'd0, taken_cnt}, 32'd2);
    chk("retire_7", {28'd0, retire_cnt}, 32'd7);

    // Memory phase: mem_done in the fifth MEM cycle
    dec_branch = NB; dec_mem = 1'b1; npc_in = 32'h104;
    fetch_ack(32'h0000_1234);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("mem_wait_req", {31'd0, ifc.imem_req}, 32'd0);
      chk("mem_wait_retire", {28'd0, retire_cnt}, 32'd7);
      step();
    end
    chk("mem_c5_req", {31'd0, ifc.imem_req}, 32'd0);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0; dec_mem = 1'b0;
    chk("mem_wb_req", {31'd0, ifc.imem_req}, 32'd0);
    chk("mem_wb_pc", pc, 32'h100);
    step();
    exp_pc = 32'h104;
    chk("mem_pc", pc, 32'h104);
    chk("mem_retire", {28'd0, retire_cnt}, 32'd8);
    chk("mem_next_req", {31'd0, ifc.imem_req}, 32'd1);

    // Misaligned target
    dec_branch = JR; npc_in = 32'h106;
    fetch_ack(32'h0);
    step(); step(); step();
    chk("mis_halted", {31'd0, halted}, 32'd1);
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_pc", pc, 32'h104);
    chk("mis_retire", {28'd0, retire_cnt}, 32'd8);
    step(); step();
    chk("halt_stay", {30'd0, halted, ifc.imem_req}, 32'd2);

    // One-cycle reset clears everything
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_pc", pc, 32'h0);
    chk("rst2_fault", {30'd0, fault, halted}, 32'd0);
    chk("rst2_cnts", {24'd0, retire_cnt, taken_cnt}, 32'd0);

    // Illegal branch code: DECODE -> HALT
    exp_pc = 32'h0;
    dec_branch = 3'b111; npc_in = 32'h4;
    fetch_ack(32'h0);
    step();
    chk("ill_halted", {31'd0, halted}, 32'd1);
    chk("ill_fault", {31'd0, fault}, 32'd1);
    step();
    chk("ill_bsel", {29'd0, branch_sel}, {29'd0, NB});
    chk("ill_pc", pc, 32'h0);

    rst = 1'b1;
    step();
    rst = 1'b0;

    // Reset in the same cycle as imem_ack
    begin
      int n = 0;
      while (!ifc.imem_req && n < 10) begin step(); n++; end
      chk("rmf_req_seen", {31'd0, ifc.imem_req}, 32'd1);
    end
    ifc.imem_ack = 1'b1; ifc.imem_rdata = 32'hDEAD_BEEF; rst = 1'b1;
    step();
    ifc.imem_ack = 1'b0; rst = 1'b0;
    chk("rmf_instr", instr, 32'h0);
    chk("rmf_idle", {29'd0, ifc.imem_req, instr_valid, halted}, 32'd0);
    chk("rmf_retire", {28'd0, retire_cnt}, 32'd0);

    // PC wrap
    exp_pc = 32'h0;
    exec_simple(JR, 32'hFFFF_FFFC);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus", pc_plus, 32'h0);
    chk("wrap_taken", {28'd0, taken_cnt}, 32'd1);
    exec_simple(NB, 32'h0);
    chk("wrap_pc0", pc, 32'h0);
    chk("wrap_retire", {28'd0, retire_cnt}, 32'd2);

    // Taken saturation (4-bit) and retire wrap
    for (int i = 0; i < 14; i++)
      exec_simple(BR, (exp_pc == 32'h0) ? 32'h200 : 32'h0);
    chk("sat_taken_max", {28'd0, taken_cnt}, 32'd15);
    chk("retire_wrap0", {28'd0, retire_cnt}, 32'd0);
    for (int i = 0; i < 6; i++)
      exec_simple(BR, (exp_pc == 32'h0) ? 32'h200 : 32'h0);
    chk("sat_taken_hold", {28'd0, taken_cnt}, 32'd15);
    chk("retire_wrap6", {28'd0, retire_cnt}, 32'd6);

    // run low at WB parks in IDLE
    dec_branch = NB; npc_in = exp_pc + 32'h4;
    fetch_ack(32'h0);
    run = 1'b0;
    step(); step(); step();
    chk("idle_req", {31'd0, ifc.imem_req}, 32'd0);
    step();
    chk("idle_req_hold", {31'd0, ifc.imem_req}, 32'd0);
    chk("idle_pc", pc, exp_pc + 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
